// File: rtl/fifo_sdp_ram.sv
// Simple-dual-port RAM: one write port, one read port with a registered output.
// No reset on the array or the read register so the tools can map it onto block RAM.
module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read port; a same-address write returns the old word.
  always_ff @(posedge clk) begin
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fwft_bram_fifo.sv
// First-word-fall-through FIFO over a block RAM. The RAM is always fetching the next
// head word, and a write that targets that address is bypassed straight to dout.
module fwft_bram_fifo #(
  parameter int DATA_WIDTH                    = 32,
  parameter int MAX_DEPTH                     = 256,
  parameter int IGNORE_SAME_LOC_RD_WR_WARNING = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  nearly_full,
  output logic                  recieve_more_than_0,
  output logic                  recieve_more_than_1
);

  localparam int AW = $clog2(MAX_DEPTH);
  localparam int CW = $clog2(MAX_DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(MAX_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(MAX_DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  nearly_full_q, nearly_full_d;
  logic                  more0_q, more0_d;
  logic                  more1_q, more1_d;
  logic                  byp_sel_q, byp_sel_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
  logic                  wr_acc_s, rd_acc_s, ram_we_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s;

  // Accept decisions, pointer wrap and occupancy.
  always_comb begin
    wr_acc_s = wr_en && !full_q;
    rd_acc_s = rd_en && more0_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (!reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_acc_s) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Flags are decoded from the next count so they line up with the data.
  always_comb begin
    full_d        = (count_d == DEPTH_C);
    nearly_full_d = (count_d >= DEPTH_C - CW'(1));
    more0_d       = (count_d != CW'(0));
    more1_d       = (count_d > CW'(1));
  end

  // The RAM reads rd_ptr_d, so it misses a write landing on that same address.
  always_comb begin
    ram_we_s = wr_acc_s && reset;
    if (!reset) begin
      byp_sel_d  = 1'b1;
      byp_data_d = '0;
    end else if (wr_acc_s && (wr_ptr_q == rd_ptr_d)) begin
      byp_sel_d  = 1'b1;
      byp_data_d = din;
    end else if (count_d == CW'(0)) begin
      byp_sel_d  = 1'b1;
      byp_data_d = '0;
    end else begin
      byp_sel_d  = 1'b0;
      byp_data_d = byp_data_q;
    end
  end

  // State register with synchronous active-low reset folded into the _d logic.
  always_ff @(posedge clk) begin
    wr_ptr_q      <= wr_ptr_d;
    rd_ptr_q      <= rd_ptr_d;
    count_q       <= count_d;
    full_q        <= full_d;
    nearly_full_q <= nearly_full_d;
    more0_q       <= more0_d;
    more1_q       <= more1_d;
    byp_sel_q     <= byp_sel_d;
    byp_data_q    <= byp_data_d;
  end

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we_s),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_addr (rd_ptr_d),
    .rd_data (ram_rdata_s)
  );

  assign dout                = byp_sel_q ? byp_data_q : ram_rdata_s;
  assign full                = full_q;
  assign nearly_full         = nearly_full_q;
  assign recieve_more_than_0 = more0_q;
  assign recieve_more_than_1 = more1_q;

`ifdef SIMULATION
  if (IGNORE_SAME_LOC_RD_WR_WARNING == 0) begin : g_warn
    always @(posedge clk) begin
      if (reset) begin
        if (wr_en && full_q) begin
          $display("%m @%0t: warning, write dropped while full", $time);
        end
        if (rd_en && !more0_q) begin
          $display("%m @%0t: warning, read ignored while empty", $time);
        end
        if (wr_acc_s && (wr_ptr_q == rd_ptr_d)) begin
          $display("%m @%0t: warning, same-location read/write", $time);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwft_bram_fifo.sv
// Randomized and directed bench for fwft_bram_fifo against a queue-based model.
module tb_fwft_bram_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          full, nearly_full, more0, more1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] model_q [$];

  fwft_bram_fifo #(
    .DATA_WIDTH (DW),
    .MAX_DEPTH  (DEPTH),
    .IGNORE_SAME_LOC_RD_WR_WARNING (0)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .din                 (din),
    .wr_en               (wr_en),
    .rd_en               (rd_en),
    .dout                (dout),
    .full                (full),
    .nearly_full         (nearly_full),
    .recieve_more_than_0 (more0),
    .recieve_more_than_1 (more1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // compare all outputs at the next falling edge.
  task automatic step(input logic rst_n, input logic w, input logic r, input logic [DW-1:0] d);
    bit acc_w, acc_r;
    reset = rst_n;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    if (!rst_n) begin
      model_q.delete();
    end else begin
      acc_w = w && (model_q.size() < DEPTH);
      acc_r = r && (model_q.size() > 0);
      if (acc_r) void'(model_q.pop_front());
      if (acc_w) model_q.push_back(d);
    end
    @(negedge clk);
    check_val("full",  {31'd0, full},        {31'd0, model_q.size() == DEPTH});
    check_val("nfull", {31'd0, nearly_full}, {31'd0, model_q.size() >= DEPTH - 1});
    check_val("more0", {31'd0, more0},       {31'd0, model_q.size() > 0});
    check_val("more1", {31'd0, more1},       {31'd0, model_q.size() > 1});
    if (model_q.size() > 0) begin
      check_val("dout", {16'd0, dout}, {16'd0, model_q[0]});
    end
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    check_val("rst_dout", {16'd0, dout}, 32'd0);

    // Single word in and out.
    step(1'b1, 1'b1, 1'b0, 16'h000A);
    step(1'b1, 1'b0, 1'b1, 16'h0000);

    // Fill to capacity, overflow attempt, then drain in order.
    for (int i = 1; i <= DEPTH + 1; i++) step(1'b1, 1'b1, 1'b0, 16'(i));
    step(1'b1, 1'b1, 1'b1, 16'h00EE);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0000);

    // Preload two, then stream through the pointer wrap.
    step(1'b1, 1'b1, 1'b0, 16'h0100);
    step(1'b1, 1'b1, 1'b0, 16'h0101);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1, 16'(16'h0200 + i));
    check_val("stream_cnt", 32'(model_q.size()), 32'd2);
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0000);

    // Empty with read and write together: read is ignored.
    step(1'b1, 1'b1, 1'b1, 16'h0BEE);
    // Count of one with pop and write together: bypass path.
    step(1'b1, 1'b1, 1'b1, 16'h0CAB);
    step(1'b1, 1'b1, 1'b1, 16'h0DAD);

    // Reset mid-operation with three words held.
    step(1'b1, 1'b1, 1'b0, 16'h0301);
    step(1'b1, 1'b1, 1'b0, 16'h0302);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0404);
    step(1'b1, 1'b0, 1'b1, 16'h0000);

    // Random traffic with varying read/write bias.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 500; i++) begin
        step(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 3) < 1 + ph % 3),
             ($urandom_range(0, 3) < 3 - ph % 3),
             16'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fwft_bram_fifo.md
# fwft_bram_fifo

First-word-fall-through FIFO backed by an inferred simple-dual-port block RAM, used on endpoint injection paths to buffer packet descriptors (id, size, destination) while the NoC packet injector is not ready. The head word is always presented on `dout` without a read request, and `rd_en` acts as an acknowledge that pops it. Depth is arbitrary (not restricted to powers of two) and may be very large (≥1,000,000 entries).

## Interface
- `DATA_WIDTH`, default 32: word width in bits.
- `MAX_DEPTH`, default 256: capacity in words, any integer ≥ 2.
- `IGNORE_SAME_LOC_RD_WR_WARNING`, default 0: 0 enables simulation-only protocol warnings; 1 suppresses them.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `din`  in  DATA_WIDTH  write data.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  pop/acknowledge of the current head word.
- `dout`  out  DATA_WIDTH  head word, valid while `recieve_more_than_0`=1.
- `full`  out  1  count == MAX_DEPTH.
- `nearly_full`  out  1  count ≥ MAX_DEPTH−1.
- `recieve_more_than_0`  out  1  count > 0 (head valid).
- `recieve_more_than_1`  out  1  count > 1.

## Operation
- Internal occupancy `count`, width $clog2(MAX_DEPTH+1); write pointer and read pointer, width $clog2(MAX_DEPTH), each wrapping from MAX_DEPTH−1 to 0.
- Write accepted iff `wr_en` & !`full`; a write while full is dropped even if `rd_en`=1.
- Read accepted iff `rd_en` & `recieve_more_than_0`; a read while empty is ignored.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- All flags are registered decodes of `count`; `dout` is the word at the read pointer, driven from a RAM output register with a bypass.
- Bypass: when a write targets the address being fetched for the next head, including writes into an empty FIFO or a FIFO about to become empty, `din` is captured directly into the output register so that `dout` is correct on the flag timing below.
- With `IGNORE_SAME_LOC_RD_WR_WARNING`=0, under `ifdef SIMULATION`, print a `$display` warning with `%m` and `$time` on a dropped write, on an ignored read, and on a same-cycle read/write to the same RAM location. These warnings have no functional effect.

## Timing
- Reset (`reset`=0 at a rising edge): pointers and count = 0. Outputs: `full`=0, `nearly_full`=0 (1 if MAX_DEPTH=1, which is not allowed), `recieve_more_than_0`=0, `recieve_more_than_1`=0, `dout`=0. RAM contents are not cleared.
- Reset asserted mid-operation: contents are discarded and the FIFO is empty on the next cycle.
- Write latency: a word written at edge N into an empty FIFO gives `recieve_more_than_0`=1 and `dout`=that word during cycle N+1.
- Pop: with `rd_en` asserted at edge N and count ≥ 2, `dout` shows the next word during cycle N+1 with no bubble.
- Flags reflect the count after edge N during cycle N+1. `full` and `nearly_full` update in the same cycle as the accepted write or read.
- Back-to-back writes and reads at 1 word/cycle are sustained indefinitely.

## Structure
- No shared package is needed. Width constants are local parameters computed with $clog2.
- One sub-module: `fifo_sdp_ram`, a simple-dual-port RAM with parameters DATA_WIDTH and DEPTH, a write port, and a registered read port, coded for block-RAM inference.
- Pointer, count, bypass and flag logic live in the top module.

## Test plan
- Reset, then write 0xA at cycle 1 -> cycle 2: `recieve_more_than_0`=1, `recieve_more_than_1`=0, `dout`=0xA; with `rd_en`=1 -> empty on cycle 3.
- MAX_DEPTH=4: write 1,2,3 -> `nearly_full`=1, `full`=0; write 4 -> `full`=1; write 5 -> dropped and warning printed; reading 4 words gives 1,2,3,4.
- MAX_DEPTH=5, with continuous simultaneous `wr_en` and `rd_en` for 20 cycles after a preload of 2 -> output order exactly matches input order across pointer wrap, and count stays at 2.
- Empty FIFO, `wr_en` and `rd_en` both high -> read ignored, count becomes 1, head equals `din`.
- Count=1 with pop and write at the same edge -> next cycle `dout` shows the new word via the bypass, and `recieve_more_than_0` stays 1.
- Drive `reset`=0 with count=3 -> next cycle all flags are 0, and a subsequent write and read return only the new data.
